// File: rtl/alu_scheduler_pkg.sv
// Shared types for the ALU scheduler: bus width, opcodes, FSM states.
package alu_pkg;

    localparam int BUS_WIDTH = 8;

    typedef enum logic [7:0] {
        ALU_ADD = 8'd0,
        ALU_SUB = 8'd1,
        ALU_MUL = 8'd2,
        ALU_EQ  = 8'd3,
        ALU_GT  = 8'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } sched_state_t;

    function automatic logic op_legal(input logic [7:0] op);
        return op <= ALU_GT;
    endfunction

endpackage

// File: rtl/alu_scheduler_if.sv
// Request, response and ALU-side bundle of the ALU scheduler.
interface alu_scheduler_if
    import alu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
);

    logic [N_REQ-1:0]           req_valid_in;
    logic [N_REQ-1:0]           req_ready_out;
    logic [N_REQ*8-1:0]         req_opcode_in;
    logic [N_REQ*BUS_WIDTH-1:0] req_operand1_in;
    logic [N_REQ*BUS_WIDTH-1:0] req_operand2_in;

    logic                 resp_valid_out;
    logic                 resp_ready_in;
    logic [IW-1:0]        resp_id_out;
    logic [BUS_WIDTH-1:0] resp_data_out;
    logic                 resp_err_out;

    logic                 alu_enable_out;
    logic [7:0]           alu_opcode_out;
    logic [BUS_WIDTH-1:0] alu_input1_out;
    logic [BUS_WIDTH-1:0] alu_input2_out;
    logic [BUS_WIDTH-1:0] alu_output_in;

    logic                 busy_out;

    modport slave (
        input  req_valid_in, req_opcode_in,
        input  req_operand1_in, req_operand2_in,
        input  resp_ready_in, alu_output_in,
        output req_ready_out,
        output resp_valid_out, resp_id_out,
        output resp_data_out, resp_err_out,
        output alu_enable_out, alu_opcode_out,
        output alu_input1_out, alu_input2_out,
        output busy_out
    );

    modport master (
        output req_valid_in, req_opcode_in,
        output req_operand1_in, req_operand2_in,
        output resp_ready_in, alu_output_in,
        input  req_ready_out,
        input  resp_valid_out, resp_id_out,
        input  resp_data_out, resp_err_out,
        input  alu_enable_out, alu_opcode_out,
        input  alu_input1_out, alu_input2_out,
        input  busy_out
    );

endinterface

// File: rtl/alu_scheduler_rr_arbiter.sv
// Rotating-priority pick: first valid requester after last, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one external combinational ALU among N_REQ requesters,
// round-robin, with a single id-tagged response channel.
module alu_scheduler
    import alu_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int ALU_LATENCY = 1
) (
    input logic            clock_in,
    input logic            reset_n_in,
    alu_scheduler_if.slave bus
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(ALU_LATENCY + 1);

    sched_state_t         state, state_n;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        last_grant;
    logic [IW-1:0]        gidx;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     ready;
    logic                 hs;
    logic                 legal;
    logic [7:0]           sel_op;
    logic [BUS_WIDTH-1:0] sel_a;
    logic [BUS_WIDTH-1:0] sel_b;

    logic [IW-1:0]        id_q;
    logic [BUS_WIDTH-1:0] data_q;
    logic                 err_q;
    logic [7:0]           opc_q;
    logic [BUS_WIDTH-1:0] in1_q;
    logic [BUS_WIDTH-1:0] in2_q;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .valid (bus.req_valid_in),
        .last  (last_grant),
        .grant (grant),
        .idx   (gidx)
    );

    // Ready is gated by reset so every output reads 0 while held in reset.
    assign ready  = (state == IDLE && reset_n_in) ? grant : '0;
    assign hs     = |(bus.req_valid_in & ready);
    assign sel_op = bus.req_opcode_in[int'(gidx)*8 +: 8];
    assign sel_a  = bus.req_operand1_in[int'(gidx)*BUS_WIDTH +: BUS_WIDTH];
    assign sel_b  = bus.req_operand2_in[int'(gidx)*BUS_WIDTH +: BUS_WIDTH];
    assign legal  = op_legal(sel_op);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (hs) state_n = legal ? EXEC : RESP;
            EXEC: if (cnt == '0) state_n = RESP;
            RESP: if (bus.resp_ready_in) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= IW'(N_REQ - 1);
            id_q       <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            opc_q      <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
        end else begin
            state <= state_n;
            if (hs) begin
                last_grant <= gidx;
                id_q       <= gidx;
                if (legal) begin
                    opc_q <= sel_op;
                    in1_q <= sel_a;
                    in2_q <= sel_b;
                    cnt   <= CW'(ALU_LATENCY - 1);
                    err_q <= 1'b0;
                end else begin
                    err_q  <= 1'b1;
                    data_q <= '0;
                end
            end
            if (state == EXEC) begin
                if (cnt == '0) data_q <= bus.alu_output_in;
                else cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.req_ready_out  = ready;
    assign bus.resp_valid_out = (state == RESP);
    assign bus.resp_id_out    = id_q;
    assign bus.resp_data_out  = data_q;
    assign bus.resp_err_out   = err_q;
    assign bus.alu_enable_out = (state == EXEC);
    assign bus.alu_opcode_out = opc_q;
    assign bus.alu_input1_out = in1_q;
    assign bus.alu_input2_out = in2_q;
    assign bus.busy_out       = (state != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a behavioural 8-bit signed ALU attached.
module tb_alu_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    int en_cnt = 0;

    always #5 clk = ~clk;

    alu_scheduler_if #(.N_REQ(4)) bus();

    alu_scheduler #(.N_REQ(4), .ALU_LATENCY(1)) dut (
        .clock_in   (clk),
        .reset_n_in (rst_n),
        .bus        (bus)
    );

    logic [7:0] alu_res;
    always_comb begin
        alu_res = 8'h00;
        case (bus.alu_opcode_out)
            8'd0: alu_res = bus.alu_input1_out + bus.alu_input2_out;
            8'd1: alu_res = bus.alu_input1_out - bus.alu_input2_out;
            8'd2: alu_res = bus.alu_input1_out * bus.alu_input2_out;
            8'd3: alu_res = {7'd0, bus.alu_input1_out == bus.alu_input2_out};
            8'd4: alu_res = {7'd0, $signed(bus.alu_input1_out) > $signed(bus.alu_input2_out)};
            default: alu_res = 8'h00;
        endcase
    end
    assign bus.alu_output_in = alu_res;

    always @(negedge clk) if (bus.alu_enable_out === 1'b1) en_cnt <= en_cnt + 1;

    task automatic set_req(input int i, input logic [7:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic v);
        bus.req_opcode_in[i*8 +: 8]   = op;
        bus.req_operand1_in[i*8 +: 8] = a;
        bus.req_operand2_in[i*8 +: 8] = b;
        bus.req_valid_in[i]           = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid_in    = '0;
        bus.req_opcode_in   = '0;
        bus.req_operand1_in = '0;
        bus.req_operand2_in = '0;
        bus.resp_ready_in   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.resp_valid_out, bus.busy_out, bus.alu_enable_out, bus.resp_err_out} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags got %b exp 0000",
                     {bus.resp_valid_out, bus.busy_out, bus.alu_enable_out, bus.resp_err_out});
        end
        checks++;
        if ({bus.alu_opcode_out, bus.alu_input1_out, bus.alu_input2_out, bus.resp_data_out} !== 32'h0) begin
            failures++;
            $display("FAIL reset_regs got %h exp 0", {bus.alu_opcode_out, bus.alu_input1_out,
                     bus.alu_input2_out, bus.resp_data_out});
        end
        do_reset();
        checks++;
        if (bus.req_ready_out !== 4'b0000 || bus.resp_id_out !== 2'd0) begin
            failures++;
            $display("FAIL reset_idle got ready=%b id=%0d exp 0000/0", bus.req_ready_out, bus.resp_id_out);
        end
    endtask

    task automatic test_single_add();
        do_reset();
        set_req(0, 8'd0, 8'd5, 8'd3, 1'b1);
        #1;
        checks++;
        if (bus.req_ready_out !== 4'b0001) begin
            failures++;
            $display("FAIL add_ready got %b exp 0001", bus.req_ready_out);
        end
        tick();
        set_req(0, 8'd0, 8'd99, 8'd99, 1'b0);
        checks++;
        if (bus.resp_valid_out !== 1'b0 || bus.alu_enable_out !== 1'b1 || bus.alu_input1_out !== 8'd5) begin
            failures++;
            $display("FAIL add_exec got v=%b en=%b in1=%h exp 0/1/05",
                     bus.resp_valid_out, bus.alu_enable_out, bus.alu_input1_out);
        end
        tick();
        checks++;
        if ({bus.resp_valid_out, bus.resp_id_out, bus.resp_data_out, bus.resp_err_out} !== {1'b1, 2'd0, 8'h08, 1'b0}) begin
            failures++;
            $display("FAIL add_resp got v=%b id=%0d d=%h e=%b exp 1/0/08/0",
                     bus.resp_valid_out, bus.resp_id_out, bus.resp_data_out, bus.resp_err_out);
        end
        tick();
        checks++;
        if (bus.resp_valid_out !== 1'b0 || bus.busy_out !== 1'b0) begin
            failures++;
            $display("FAIL add_done got v=%b busy=%b exp 0/0", bus.resp_valid_out, bus.busy_out);
        end
    endtask

    task automatic test_round_robin();
        int n;
        logic [1:0] exp_id;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 8'd0, 8'(i), 8'(i), 1'b1);
        for (int r = 0; r < 5; r++) begin
            exp_id = 2'(r % 4);
            n = 0;
            while (bus.resp_valid_out !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (n >= 10) begin
                failures++;
                $display("FAIL rr_timeout resp %0d got none exp resp_valid", r);
            end
            checks++;
            if (bus.resp_id_out !== exp_id || bus.resp_data_out !== 8'(2 * r % 8)) begin
                failures++;
                $display("FAIL rr_resp %0d got id=%0d d=%h exp id=%0d d=%h",
                         r, bus.resp_id_out, bus.resp_data_out, exp_id, 8'(2 * r % 8));
            end
            tick();
        end
        bus.req_valid_in = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.resp_ready_in = 1'b0;
        set_req(1, 8'd0, 8'd10, 8'd20, 1'b1);
        #1;
        checks++;
        if (bus.req_ready_out !== 4'b0010) begin
            failures++;
            $display("FAIL bp_ready got %b exp 0010", bus.req_ready_out);
        end
        tick();
        set_req(1, 8'd0, 8'd0, 8'd0, 1'b0);
        tick();
        set_req(0, 8'd0, 8'd1, 8'd1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if ({bus.resp_valid_out, bus.resp_id_out, bus.resp_data_out, bus.req_ready_out} !==
                {1'b1, 2'd1, 8'h1E, 4'b0000}) begin
                failures++;
                $display("FAIL bp_hold cyc %0d got v=%b id=%0d d=%h rdy=%b exp 1/1/1e/0000", c,
                         bus.resp_valid_out, bus.resp_id_out, bus.resp_data_out, bus.req_ready_out);
            end
            tick();
        end
        bus.resp_ready_in = 1'b1;
        #1;
        tick();
        checks++;
        if (bus.resp_valid_out !== 1'b0 || bus.req_ready_out !== 4'b0001) begin
            failures++;
            $display("FAIL bp_release got v=%b rdy=%b exp 0/0001", bus.resp_valid_out, bus.req_ready_out);
        end
        bus.req_valid_in = '0;
    endtask

    task automatic test_arith();
        logic [7:0] ops [4] = '{8'd1, 8'd2, 8'd4, 8'd3};
        logic [7:0] av  [4] = '{8'd3, 8'd16, 8'h80, 8'd7};
        logic [7:0] bv  [4] = '{8'd5, 8'd16, 8'h01, 8'd7};
        logic [7:0] ex  [4] = '{8'hFE, 8'h00, 8'h00, 8'h01};
        do_reset();
        for (int t = 0; t < 4; t++) begin
            set_req(3, ops[t], av[t], bv[t], 1'b1);
            #1;
            checks++;
            if (bus.req_ready_out !== 4'b1000) begin
                failures++;
                $display("FAIL arith_ready %0d got %b exp 1000", t, bus.req_ready_out);
            end
            tick();
            bus.req_valid_in = '0;
            tick();
            checks++;
            if ({bus.resp_valid_out, bus.resp_id_out, bus.resp_data_out, bus.resp_err_out} !==
                {1'b1, 2'd3, ex[t], 1'b0}) begin
                failures++;
                $display("FAIL arith_resp op %0d got v=%b id=%0d d=%h e=%b exp 1/3/%h/0", ops[t],
                         bus.resp_valid_out, bus.resp_id_out, bus.resp_data_out, bus.resp_err_out, ex[t]);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        int en0;
        do_reset();
        en0 = en_cnt;
        set_req(2, 8'h07, 8'd9, 8'd9, 1'b1);
        #1;
        checks++;
        if (bus.req_ready_out !== 4'b0100) begin
            failures++;
            $display("FAIL ill_ready got %b exp 0100", bus.req_ready_out);
        end
        tick();
        bus.req_valid_in = '0;
        checks++;
        if ({bus.resp_valid_out, bus.resp_id_out, bus.resp_data_out, bus.resp_err_out} !== {1'b1, 2'd2, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL ill_resp got v=%b id=%0d d=%h e=%b exp 1/2/00/1",
                     bus.resp_valid_out, bus.resp_id_out, bus.resp_data_out, bus.resp_err_out);
        end
        checks++;
        if (bus.alu_opcode_out !== 8'h00 || bus.alu_input1_out !== 8'h00) begin
            failures++;
            $display("FAIL ill_aluregs got op=%h in1=%h exp 00/00", bus.alu_opcode_out, bus.alu_input1_out);
        end
        tick();
        checks++;
        if (bus.resp_valid_out !== 1'b0 || en_cnt !== en0) begin
            failures++;
            $display("FAIL ill_enable got v=%b en_cycles=%0d exp 0/0", bus.resp_valid_out, en_cnt - en0);
        end
    endtask

    task automatic test_reset_mid_op();
        int seen;
        do_reset();
        set_req(0, 8'd0, 8'd1, 8'd2, 1'b1);
        tick();
        bus.req_valid_in = '0;
        checks++;
        if (bus.busy_out !== 1'b1 || bus.alu_enable_out !== 1'b1) begin
            failures++;
            $display("FAIL rst_exec got busy=%b en=%b exp 1/1", bus.busy_out, bus.alu_enable_out);
        end
        rst_n = 1'b0;
        set_req(1, 8'd0, 8'd4, 8'd4, 1'b1);
        set_req(0, 8'd0, 8'd6, 8'd6, 1'b1);
        #1;
        checks++;
        if ({bus.resp_valid_out, bus.busy_out, bus.alu_enable_out, bus.req_ready_out,
             bus.alu_opcode_out, bus.alu_input1_out, bus.alu_input2_out, bus.resp_data_out} !== '0) begin
            failures++;
            $display("FAIL rst_async got v=%b busy=%b en=%b rdy=%b in1=%h d=%h exp all 0",
                     bus.resp_valid_out, bus.busy_out, bus.alu_enable_out, bus.req_ready_out,
                     bus.alu_input1_out, bus.resp_data_out);
        end
        bus.req_valid_in = '0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.resp_valid_out === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_noresp got %0d resp cycles exp 0", seen);
        end
        set_req(1, 8'd0, 8'd4, 8'd4, 1'b1);
        set_req(0, 8'd0, 8'd6, 8'd6, 1'b1);
        #1;
        checks++;
        if (bus.req_ready_out !== 4'b0001) begin
            failures++;
            $display("FAIL rst_first_grant got %b exp 0001", bus.req_ready_out);
        end
        bus.req_valid_in = '0;
    endtask

    initial begin
        bus.req_valid_in    = '0;
        bus.req_opcode_in   = '0;
        bus.req_operand1_in = '0;
        bus.req_operand2_in = '0;
        bus.resp_ready_in   = 1'b1;
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_arith();
        test_illegal();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
